seg_scan_driver: RTL and testbench

Time-multiplexed scan driver for an 8-digit common-select seven-segment display. Holds a 32-bit value, steps through its hex digits at a programmable rate, and presents one nibble plus a one-hot digit select each scan slot. Sits directly upstream of the seven-segment decoder: `nibble[3]..nibble[0]` feed the decoder inputs `x3..x0`, and `sel` drives the digit enables. Value updates are double-buffered and committed only at frame boundaries, so a digit never changes value mid-frame.

---
 rtl/seg_scan_driver.sv | 80 ++++++++
 tb/tb_seg_scan_driver.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Scan driver for a multiplexed seven-segment display: walks the hex digits of a
// double-buffered value, one slot every DIV cycles, with optional leading-zero blanking.
module seg_scan_driver #(
   parameter int DIGITS = 8,
   parameter int DIV    = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  blank_lz,
   output logic [3:0]            nibble,
   output logic [DIGITS-1:0]     sel,
   output logic                  blank,
   output logic                  pending,
   output logic                  frame_start
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   disp;
   logic [4*DIGITS-1:0]   shadow;
   logic [IW-1:0]         hi;
   logic                  tick;
   logic                  last;
   logic                  wrap;

   assign tick = (cnt == CW'(DIV - 1));
   assign last = (idx == IW'(DIGITS - 1));
   assign wrap = tick && last;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         idx         <= '0;
         disp        <= '0;
         shadow      <= '0;
         pending     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         cnt         <= tick ? '0 : cnt + CW'(1);
         frame_start <= wrap;
         if (tick)
            idx <= last ? '0 : idx + IW'(1);
         // Commit takes the old shadow; a same-cycle load stays pending for the next wrap.
         if (wrap && pending)
            disp <= shadow;
         if (load) begin
            shadow  <= value;
            pending <= 1'b1;
         end else if (wrap) begin
            pending <= 1'b0;
         end
      end
   end

   // Highest nonzero digit of the displayed value; 0 when the value is zero.
   always_comb begin
      hi = '0;
      for (int i = 1; i < DIGITS; i++)
         if (disp[4*i +: 4] != 4'd0)
            hi = IW'(i);
   end

   always_comb begin
      nibble = 4'd0;
      sel    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         sel[i] = (idx == IW'(i));
         if (idx == IW'(i))
            nibble = disp[4*i +: 4];
      end
   end

   assign blank = blank_lz && (idx > hi);

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at DIGITS=8, DIV=4 (32-cycle frame).
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [31:0] value;
   logic        blank_lz;
   logic [3:0]  nibble;
   logic [7:0]  sel;
   logic        blank;
   logic        pending;
   logic        frame_start;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   seg_scan_driver #(.DIGITS(8), .DIV(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .value       (value),
      .blank_lz    (blank_lz),
      .nibble      (nibble),
      .sel         (sel),
      .blank       (blank),
      .pending     (pending),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   // Checks the cycle, then advances one clock; slot = cyc/4, frame = 32 cycles.
   task automatic scan(input string tag, input logic [31:0] d, input logic pend,
                       input logic [7:0] bmask, input int n);
      int slot;
      repeat (n) begin
         slot = (cyc / 4) % 8;
         chk({tag, "_sel"},    32'(sel),         32'(8'd1 << slot));
         chk({tag, "_nib"},    32'(nibble),      32'(d[4*slot +: 4]));
         chk({tag, "_blank"},  32'(blank),       32'(bmask[slot]));
         chk({tag, "_pend"},   32'(pending),     32'(pend));
         chk({tag, "_fstart"}, 32'(frame_start), 32'((cyc % 32 == 0) && (cyc != 0)));
         step(1);
      end
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;
      step(2);
      chk("rst_sel",    32'(sel),         32'h1);
      chk("rst_nib",    32'(nibble),      32'h0);
      chk("rst_blank",  32'(blank),       32'h0);
      chk("rst_pend",   32'(pending),     32'h0);
      chk("rst_fstart", 32'(frame_start), 32'h0);
      reset = 1'b0;
      cyc = 0;

      // 1: idle scan, two full frames
      scan("s1", 32'h0, 1'b0, 8'h00, 64);

      // 2: load at slot 3, commit at the wrap
      scan("s2_pre", 32'h0, 1'b0, 8'h00, 12);
      load = 1'b1; value = 32'h8765_4321;
      step(1);
      load = 1'b0;
      chk("s2_pend_next", 32'(pending), 32'h1);
      scan("s2_old", 32'h0, 1'b1, 8'h00, 19);
      scan("s2_new", 32'h8765_4321, 1'b0, 8'h00, 32);

      // 3: leading-zero blanking on 0xA5, then on zero
      blank_lz = 1'b1;
      load = 1'b1; value = 32'h0000_00A5;
      step(1);
      load = 1'b0;
      scan("s3_old", 32'h8765_4321, 1'b1, 8'h00, 31);
      scan("s3_a5", 32'h0000_00A5, 1'b0, 8'hFC, 1);
      load = 1'b1; value = 32'h0;
      scan("s3_a5", 32'h0000_00A5, 1'b0, 8'hFC, 1);
      load = 1'b0;
      scan("s3_a5p", 32'h0000_00A5, 1'b1, 8'hFC, 30);
      scan("s3_zero", 32'h0, 1'b0, 8'hFE, 32);
      blank_lz = 1'b0;

      // 4: second load lands exactly on the wrap tick
      load = 1'b1; value = 32'h1111_1111;
      scan("s4_pre", 32'h0, 1'b0, 8'h00, 1);
      load = 1'b0;
      scan("s4_wait", 32'h0, 1'b1, 8'h00, 30);
      load = 1'b1; value = 32'h2222_2222;
      scan("s4_wrap", 32'h0, 1'b1, 8'h00, 1);
      load = 1'b0;
      scan("s4_ones", 32'h1111_1111, 1'b1, 8'h00, 32);

      // 5: two loads in one frame, only the last is shown
      scan("s5_twos", 32'h2222_2222, 1'b0, 8'h00, 2);
      load = 1'b1; value = 32'hAAAA_AAAA;
      scan("s5_lda", 32'h2222_2222, 1'b0, 8'h00, 1);
      load = 1'b0;
      scan("s5_mid", 32'h2222_2222, 1'b1, 8'h00, 9);
      load = 1'b1; value = 32'hBBBB_BBBB;
      scan("s5_ldb", 32'h2222_2222, 1'b1, 8'h00, 1);
      load = 1'b0;
      scan("s5_end", 32'h2222_2222, 1'b1, 8'h00, 19);
      scan("s5_b", 32'hBBBB_BBBB, 1'b0, 8'h00, 32);

      // 6: reset mid-slot at idx 5 with a load pending
      load = 1'b1; value = 32'h1234_5678;
      scan("s6_ld", 32'hBBBB_BBBB, 1'b0, 8'h00, 1);
      load = 1'b0;
      scan("s6_pre", 32'hBBBB_BBBB, 1'b1, 8'h00, 21);
      chk("s6_idx5", 32'(sel), 32'h20);
      reset = 1'b1;
      step(1);
      chk("s6_sel",  32'(sel),     32'h1);
      chk("s6_nib",  32'(nibble),  32'h0);
      chk("s6_pend", 32'(pending), 32'h0);
      reset = 1'b0;
      cyc = 0;
      scan("s6_post", 32'h0, 1'b0, 8'h00, 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
